// File: rtl/ahb_pkg.sv
// ahb_pkg -- shared definitions for the AHB read master slice.
//   HTRANS / HSIZE / HBURST encodings, read-master FSM state type,
//   read-data FIFO geometry and the latched command record.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ADDR  = 2'b01,
        ST_DRAIN = 2'b10
    } rd_state_e;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Active command: next address to issue and words still to issue.
    typedef struct packed {
        logic [31:0] addr;
        logic [11:0] cnt;
    } rd_cmd_t;

endpackage

// File: rtl/ahb_rd_master_if.sv
// ahb_rd_master_if -- AHB-Lite read-side bus bundle.
//   master modport: drives HADDR/HTRANS/HWRITE/HSIZE/HBURST,
//                   samples HREADY/HRDATA/HRESP.
//   slave  modport: the mirror image.
interface ahb_rd_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_rd_fifo.sv
// ahb_rd_fifo -- small synchronous FIFO for read-data words.
//   clk/rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata  : write strobe and data; accepted when not full, or when
//                 full and popping in the same cycle
//   pop/rdata   : read strobe and head word; rdata reads 0 while empty
//   full/empty  : status flags
//   count       : current occupancy 0..DEPTH
module ahb_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wptr, rptr;
    logic [AW:0]                 cnt;
    logic                        do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; rdata is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ahb_rd_master.sv
// ahb_rd_master -- AHB-Lite master that reads word_cnt 32-bit words from
// start_addr using SINGLE NONSEQ transfers and streams them out through a
// 4-deep FIFO with valid/ready.
//   HCLK, HRESET           : clock, asynchronous active-high reset
//   start/start_addr/word_cnt : command strobe (sampled in IDLE), byte
//                            address (bits[1:0] ignored), word count 0..2048
//   busy, done             : command in progress / one-cycle completion pulse
//   ahb (master modport)   : AHB address/control out, HREADY/HRDATA/HRESP in
//   rd_data/rd_valid/rd_ready : read-data stream
//   err                    : sticky error flag, only when AHB_RD_MASTER_ERR_EN
//                            is defined (ERROR responses abort the command);
//                            otherwise HRESP is ignored.
module ahb_rd_master
    import ahb_pkg::*;
(
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            start,
    input  logic [31:0]     start_addr,
    input  logic [11:0]     word_cnt,
    output logic            busy,
    output logic            done,
    ahb_rd_master_if.master ahb,
    output logic [31:0]     rd_data,
    output logic            rd_valid,
    input  logic            rd_ready
`ifdef AHB_RD_MASTER_ERR_EN
    ,
    output logic            err
`endif
);
    rd_state_e             state, state_nxt;
    rd_cmd_t               cmd_q, cmd_nxt;
    logic                  dp_pend, dp_pend_nxt;  // a data phase is in flight
    logic                  done_nxt;
    logic                  start_acc;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic                  fifo_full, fifo_empty;
    logic [3:0]            occ_sum;
    logic                  credit_ok, issue, accept, data_done;
    logic                  push, pop, err_hit, err_end;
    logic                  unused_sig;

    assign unused_sig = ^{start_addr[1:0], fifo_full, ahb.HRESP};

`ifdef AHB_RD_MASTER_ERR_EN
    // ERROR seen in the data phase: cancel the address phase on the bus now
    // (first ERROR cycle has HREADY=0) and drop the errored word.
    assign err_hit = dp_pend & ahb.HRESP;
`else
    assign err_hit = 1'b0;
`endif
    assign err_end = err_hit & ahb.HREADY;

    // A word slot is reserved for the in-flight data phase, so the FIFO can
    // never be pushed beyond its depth.
    assign occ_sum   = {1'b0, fifo_cnt} + {3'b000, dp_pend};
    assign credit_ok = (occ_sum < 4'(FIFO_DEPTH));

    // While HREADY is low neither occupancy can grow nor dp_pend change, so
    // an issued NONSEQ stays on the bus until accepted.
    assign issue     = (state == ST_ADDR) & credit_ok & ~err_hit;
    assign accept    = issue & ahb.HREADY;
    assign data_done = dp_pend & ahb.HREADY;
    assign push      = data_done & ~err_hit;
    assign pop       = rd_valid & rd_ready;

    assign ahb.HADDR  = cmd_q.addr;
    assign ahb.HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.HWRITE = 1'b0;
    assign ahb.HSIZE  = HSIZE_WORD;
    assign ahb.HBURST = HBURST_SINGLE;

    assign busy     = (state != ST_IDLE);
    assign rd_valid = ~fifo_empty;

    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd_q;
        dp_pend_nxt = dp_pend;
        done_nxt    = 1'b0;
        start_acc   = 1'b0;

        if (data_done) dp_pend_nxt = 1'b0;
        if (accept) begin
            dp_pend_nxt  = 1'b1;
            cmd_nxt.addr = cmd_q.addr + 32'd4;  // wraps FFFF_FFFC -> 0
            cmd_nxt.cnt  = cmd_q.cnt - 12'd1;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc    = 1'b1;
                    cmd_nxt.addr = {start_addr[31:2], 2'b00};
                    cmd_nxt.cnt  = word_cnt;
                    // Zero-length command passes straight through DRAIN.
                    state_nxt    = (word_cnt == 12'd0) ? ST_DRAIN : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (err_end) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (accept && cmd_q.cnt == 12'd1) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!dp_pend || ahb.HREADY) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            cmd_q   <= '0;
            dp_pend <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cmd_q   <= cmd_nxt;
            dp_pend <= dp_pend_nxt;
            done    <= done_nxt;
        end
    end

`ifdef AHB_RD_MASTER_ERR_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)         err <= 1'b0;
        else if (start_acc) err <= 1'b0;
        else if (err_end)   err <= 1'b1;
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

    ahb_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push),
        .wdata (ahb.HRDATA),
        .pop   (pop),
        .rdata (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_ahb_rd_master.sv
// tb_ahb_rd_master -- directed + randomized bench for ahb_rd_master.
// The bench plays the AHB slave (memory word = word_of(address)) and the
// stream consumer, logs accepted addresses and delivered words, and checks
// them against the address sequence start+4*i implied by each command.
module tb_ahb_rd_master;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic [31:0] start_addr;
    logic [11:0] word_cnt;
    logic        busy, done;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
`ifdef AHB_RD_MASTER_ERR_EN
    logic        err;
`endif

    ahb_rd_master_if bus();

    ahb_rd_master dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .start      (start),
        .start_addr (start_addr),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .done       (done),
        .ahb        (bus),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready)
`ifdef AHB_RD_MASTER_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 HCLK = ~HCLK;

    int n_chk = 0, n_fail = 0;
    int cyc_n = 0, start_cyc = 0;
    int rdy_mode = 0, hr_mode = 0;          // rdy: 0=always 1=never 2=random
    int stall_word = -1, stall_len = 0, stall_cnt = 0;
    int err_word = -1, err_ph = 0;
    logic start_req = 1'b0, junk_en = 1'b0;
    logic dp_v = 1'b0;
    logic [31:0] dp_addr = '0;
    int dp_idx = 0, acc_n = 0, popped_n = 0;
    logic [31:0] acc_q[$], got_q[$];
    int acc_cyc[$], pop_cyc[$];
    int done_n, done_cyc, busy_n, busy_first, nonseq_n, hold_viol, max_infl;
    logic prev_stall = 1'b0, prev_resp = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        acc_q.delete(); got_q.delete(); acc_cyc.delete(); pop_cyc.delete();
        acc_n = 0; popped_n = 0; done_n = 0; done_cyc = -1; busy_n = 0;
        busy_first = -1; nonseq_n = 0; hold_viol = 0; max_infl = 0;
        stall_cnt = 0; err_ph = 0;
    endtask

    // One clock: drive slave/consumer at negedge, observe 1 time unit later.
    task automatic cyc();
        logic hr, resp, acc;
        @(negedge HCLK);
        start     = start_req;
        start_req = 1'b0;
        hr = 1'b1; resp = 1'b0;
        if (dp_v) begin
            if (dp_idx == err_word) begin
                resp = 1'b1; hr = (err_ph == 1); err_ph++;
            end else if (dp_idx == stall_word && stall_cnt < stall_len) begin
                hr = 1'b0; stall_cnt++;
            end else if (hr_mode == 1) begin
                hr = ($urandom_range(0, 2) != 0);
            end
        end
        bus.HREADY = hr;
        bus.HRESP  = resp;
        bus.HRDATA = dp_v ? word_of(dp_addr) : $urandom;
        rd_ready   = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        if (prev_stall && !prev_resp && (bus.HTRANS !== 2'b10 || bus.HADDR !== prev_addr))
            hold_viol++;
        prev_stall = (bus.HTRANS == 2'b10) && !hr;
        prev_addr  = bus.HADDR;
        prev_resp  = resp;
        if (bus.HTRANS == 2'b10) nonseq_n++;
        acc = (bus.HTRANS == 2'b10) && hr;
        if (dp_v && hr) dp_v = 1'b0;
        if (acc) begin
            dp_v = 1'b1; dp_addr = bus.HADDR; dp_idx = acc_n; acc_n++;
            acc_q.push_back(bus.HADDR); acc_cyc.push_back(cyc_n);
        end
        if (rd_valid && rd_ready) begin
            got_q.push_back(rd_data); pop_cyc.push_back(cyc_n); popped_n++;
        end
        if (acc_n - popped_n > max_infl) max_infl = acc_n - popped_n;
        if (busy) begin
            busy_n++;
            if (busy_first < 0) busy_first = cyc_n;
            if (junk_en) begin      // must be ignored: DUT is not in IDLE
                start = 1'b1; start_addr = $urandom; word_cnt = 12'($urandom_range(1, 2048));
            end
        end
        if (done) begin done_n++; done_cyc = cyc_n; end
        cyc_n++;
    endtask

    task automatic issue(input logic [31:0] a, input int n);
        clear_log();
        start_req = 1'b1; start_addr = a; word_cnt = 12'(n);
        start_cyc = cyc_n;
        cyc();
    endtask

    task automatic finish_cmd(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (done_n > 0 && !rd_valid && !busy) break;
        end
    endtask

    task automatic check_cmd(input string tag, input logic [31:0] a, input int n_acc, input int n_words);
        logic [31:0] base;
        base = {a[31:2], 2'b00};
        chk({tag, " done count"}, done_n, 1);
        chk({tag, " addr count"}, acc_q.size(), n_acc);
        for (int i = 0; i < acc_q.size() && i < n_acc; i++)
            chk({tag, " addr"}, acc_q[i], base + 32'(4 * i));
        chk({tag, " word count"}, got_q.size(), n_words);
        for (int i = 0; i < got_q.size() && i < n_words; i++)
            chk({tag, " data"}, got_q[i], word_of(base + 32'(4 * i)));
        chk({tag, " hold"}, hold_viol, 0);
        chk({tag, " credit"}, 32'(max_infl <= 4), 1);
    endtask

    task automatic reset_pulse(input string tag);
        #3 HRESET = 1'b1; start = 1'b0;
        #1;
        chk({tag, " HTRANS"}, 32'(bus.HTRANS), 0);
        chk({tag, " HADDR"}, bus.HADDR, 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " rd_valid"}, 32'(rd_valid), 0);
        chk({tag, " rd_data"}, rd_data, 0);
`ifdef AHB_RD_MASTER_ERR_EN
        chk({tag, " err"}, 32'(err), 0);
`endif
        @(negedge HCLK);
        @(negedge HCLK) HRESET = 1'b0;
        dp_v = 1'b0; prev_stall = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int n;
        HRESET = 1'b1; start = 1'b0; start_addr = '0; word_cnt = '0; rd_ready = 1'b0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        clear_log();
        @(negedge HCLK); #1;
        chk("reset HTRANS", 32'(bus.HTRANS), 0);
        chk("reset HADDR", bus.HADDR, 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset rd_valid", 32'(rd_valid), 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset HWRITE", 32'(bus.HWRITE), 0);
        chk("reset HSIZE", 32'(bus.HSIZE), 2);
        chk("reset HBURST", 32'(bus.HBURST), 0);
        @(negedge HCLK) HRESET = 1'b0;

        // Basic 4-word read, full-speed bus and consumer.
        issue(32'h100, 4);
        finish_cmd(60);
        check_cmd("basic", 32'h100, 4, 4);
        chk("basic first NONSEQ cycle", 32'(acc_cyc[0] - start_cyc), 1);
        chk("basic addr back-to-back", 32'(acc_cyc[3] - acc_cyc[0]), 3);
        // rd_valid appears 2 clock edges after the edge that samples start.
        chk("basic first-word latency", 32'(pop_cyc[0] - start_cyc - 1), 2);
        chk("basic 1 word/cycle", 32'(pop_cyc[3] - pop_cyc[0]), 3);

        // Consumer stalled: credits allow exactly 4 issued, then idle.
        rdy_mode = 1;
        issue(32'h2000, 8);
        repeat (12) cyc();
        chk("rdy0 NONSEQ seen", nonseq_n, 4);
        chk("rdy0 accepted", acc_n, 4);
        chk("rdy0 rd_valid", 32'(rd_valid), 1);
        chk("rdy0 busy", 32'(busy), 1);
        rdy_mode = 0;
        finish_cmd(80);
        check_cmd("rdy0", 32'h2000, 8, 8);

        // HREADY low 3 cycles in the 2nd data phase.
        stall_word = 1; stall_len = 3;
        issue(32'h300, 4);
        finish_cmd(60);
        check_cmd("stall", 32'h300, 4, 4);
        chk("stall NONSEQ held", nonseq_n, 7);
        stall_word = -1;

        // Zero-length command.
        issue(32'h400, 0);
        finish_cmd(20);
        chk("zero done count", done_n, 1);
        chk("zero NONSEQ", nonseq_n, 0);
        chk("zero busy cycles", busy_n, 1);
        chk("zero done after busy", 32'(done_cyc - busy_first), 1);

        // Address wrap.
        issue(32'hFFFF_FFF8, 3);
        finish_cmd(60);
        check_cmd("wrap", 32'hFFFF_FFF8, 3, 3);

        // Random commands, random HREADY stalls, random consumer, stray starts.
        hr_mode = 1; rdy_mode = 2; junk_en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            a = $urandom;
            n = $urandom_range(1, 24);
            issue(a, n);
            finish_cmd(100 + 20 * n);
            check_cmd("random", a, n, n);
        end
        hr_mode = 0; rdy_mode = 0; junk_en = 1'b0;

`ifdef AHB_RD_MASTER_ERR_EN
        // ERROR on word 2 of 5.
        err_word = 1;
        issue(32'h500, 5);
        finish_cmd(60);
        check_cmd("error", 32'h500, 2, 1);
        chk("error NONSEQ total", nonseq_n, 2);
        chk("error err flag", 32'(err), 1);
        err_word = -1;
        reset_pulse("err reset");
        err_word = 1;
        issue(32'h600, 5);
        finish_cmd(60);
        chk("error2 err flag", 32'(err), 1);
        err_word = -1;
        issue(32'h700, 2);
        finish_cmd(40);
        check_cmd("after error", 32'h700, 2, 2);
        chk("err cleared by start", 32'(err), 0);
`endif

        // Reset mid-burst with a full FIFO, then a clean command.
        rdy_mode = 1;
        issue(32'h800, 16);
        repeat (6) cyc();
        reset_pulse("midreset");
        rdy_mode = 0;
        issue(32'h900, 3);
        finish_cmd(40);
        check_cmd("post reset", 32'h900, 3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
